// File: rtl/readout_sched_if.sv
// Host-link bundle of readout_sched: one captured word plus its source index, valid/ready.
// With READOUT_TIMESTAMP_EN the bundle also carries the req-cycle timestamp.
interface readout_sched_if #(
  parameter int WORD_W = 36,
  parameter int IDX_W  = 3
);
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  logic [IDX_W-1:0]  src;
`ifdef READOUT_TIMESTAMP_EN
  logic [31:0]       ts;

  modport master (output valid, data, src, ts, input ready);
  modport slave  (input valid, data, src, ts, output ready);
`else
  modport master (output valid, data, src, input ready);
  modport slave  (input valid, data, src, output ready);
`endif
endinterface

// File: rtl/readout_sched.sv
// Round-robin serial readout of NBLK block FIFOs, flush sequencing and sticky overflow flags;
// word valid WORD_W+1+SKEW cycles after its req, no req while out_valid&&!out_ready; READOUT_TIMESTAMP_EN adds out_ts.
module readout_sched #(
  parameter int NBLK          = 8,
  parameter int IDX_W         = 3,
  parameter int WORD_W        = 36,
  parameter int SKEW          = 0,
  parameter int RST_CYCLES    = 5,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic            i_fifo_clk,
  input  logic            i_fifo_rst_in,
  input  logic [NBLK-1:0] i_blk_empty,
  input  logic [NBLK-1:0] i_blk_oflow,
  input  logic [NBLK-1:0] i_blk_bit,
  output logic [NBLK-1:0] o_blk_req,
  output logic            o_blk_rst,
  input  logic            i_flush,
  input  logic            i_oflow_clr,
  output logic [NBLK-1:0] o_oflow_sticky,
  output logic            o_busy,
  readout_sched_if.master host
);

  localparam int SHIFT_LEN = SKEW + WORD_W;
  localparam int CNT_MAX   = (SHIFT_LEN > RST_CYCLES) ?
                             ((SHIFT_LEN > SETTLE_CYCLES) ? SHIFT_LEN : SETTLE_CYCLES) :
                             ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_SKEW       = CNT_W'(SKEW);
  localparam logic [CNT_W-1:0] C_SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] C_RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SET_LAST   = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH_RST,
    S_FLUSH_SETTLE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_src;
  logic              r_blk_rst;
  logic [NBLK-1:0]   r_sticky;
`ifdef READOUT_TIMESTAMP_EN
  logic [31:0]       r_ts;
  logic [31:0]       r_ts_req;
  logic [31:0]       r_out_ts;
`endif

  logic              w_gnt_vld;
  logic [IDX_W-1:0]  w_gnt;
  logic              w_eligible;
  logic              w_req_go;
  logic              w_bit;
  logic [WORD_W-1:0] w_word;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NBLK) k = k - NBLK;
    return IDX_W'(k);
  endfunction

  // Scan from the farthest offset down so the nearest non-empty block at or after r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (!i_blk_empty[rot_idx(r_ptr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = rot_idx(r_ptr, i);
      end
    end
  end

  assign w_eligible = w_gnt_vld && (!r_out_valid || host.ready);
  assign w_req_go   = (r_state == S_IDLE) && !i_flush && w_eligible;
  assign o_blk_req  = w_req_go ? (NBLK'(1) << w_gnt) : '0;

  assign w_bit  = i_blk_bit[r_gnt];
  assign w_word = {w_bit, r_shift[WORD_W-1:1]};

  always_ff @(posedge i_fifo_clk) begin
    if (i_fifo_rst_in) begin
      r_state     <= S_FLUSH_RST;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_blk_rst   <= 1'b1;
      r_sticky    <= '0;
`ifdef READOUT_TIMESTAMP_EN
      r_ts        <= '0;
      r_ts_req    <= '0;
      r_out_ts    <= '0;
`endif
    end else begin
      r_sticky <= (r_sticky & ~{NBLK{i_oflow_clr}}) | i_blk_oflow;
`ifdef READOUT_TIMESTAMP_EN
      r_ts     <= r_ts + 32'd1;
`endif
      if (r_out_valid && host.ready) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_flush) begin
            r_state     <= S_FLUSH_RST;
            r_cnt       <= '0;
            r_blk_rst   <= 1'b1;
            r_out_valid <= 1'b0;
          end else if (w_eligible) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_gnt   <= w_gnt;
            r_ptr   <= (w_gnt == IDX_W'(NBLK - 1)) ? '0 : w_gnt + 1'b1;
`ifdef READOUT_TIMESTAMP_EN
            r_ts_req <= r_ts;
`endif
          end
        end
        S_SHIFT: begin
          // First SKEW cycles after the req cycle only cover the board delay on blk_bit.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt >= C_SKEW) r_shift <= w_word;
          if (r_cnt == C_SHIFT_LAST) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_src   <= r_gnt;
`ifdef READOUT_TIMESTAMP_EN
            r_out_ts    <= r_ts_req;
`endif
          end
        end
        S_FLUSH_RST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state   <= S_FLUSH_SETTLE;
            r_cnt     <= '0;
            r_blk_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FLUSH_SETTLE: begin
          r_ptr <= '0;
          if (r_cnt == C_SET_LAST) r_state <= S_IDLE;
          else                     r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_FLUSH_RST;
      endcase
    end
  end

  assign o_blk_rst      = r_blk_rst;
  assign o_oflow_sticky = r_sticky;
  assign o_busy         = (r_state != S_IDLE);
  assign host.valid     = r_out_valid;
  assign host.data      = r_out_data;
  assign host.src       = r_out_src;
`ifdef READOUT_TIMESTAMP_EN
  assign host.ts        = r_out_ts;
`endif

endmodule

// File: tb/tb_readout_sched.sv
// Bench for readout_sched: directed sequences plus random traffic against a timeline model of the scheduler.
module tb_readout_sched;
  localparam int NBLK   = 8;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 36;
  localparam int RST_C  = 5;
  localparam int SET_C  = 8;
`ifdef READOUT_TIMESTAMP_EN
  localparam int SKEW   = 2;
`else
  localparam int SKEW   = 0;
`endif
  localparam int LAT    = WORD_W + 1 + SKEW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [NBLK-1:0] empty, oflow, bits, req, sticky;
  logic            blk_rst, flush, clr, busy;

  readout_sched_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) host ();

  readout_sched #(
    .NBLK(NBLK), .IDX_W(IDX_W), .WORD_W(WORD_W), .SKEW(SKEW),
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C)
  ) dut (
    .i_fifo_clk(clk), .i_fifo_rst_in(rst),
    .i_blk_empty(empty), .i_blk_oflow(oflow), .i_blk_bit(bits),
    .o_blk_req(req), .o_blk_rst(blk_rst),
    .i_flush(flush), .i_oflow_clr(clr),
    .o_oflow_sticky(sticky), .o_busy(busy),
    .host(host)
  );

  typedef struct {
    logic [NBLK-1:0] oflow;
    logic            clr;
    logic [NBLK-1:0] exp;
  } sticky_vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [NBLK-1:0] drv_empty = '1, drv_oflow = '0;
  logic            drv_clr = 1'b0, drv_flush = 1'b0, drv_ready = 1'b1;
  logic            force_en = 1'b0;
  logic [WORD_W-1:0] force_word = '0;

  logic [WORD_W-1:0] blk_word [NBLK];
  int                blk_start [NBLK];

  // Model timeline: cycle the scheduler is next free, start of flush reset window, last-bit cycle.
  int m_free_at, m_rst_from, m_done, ptr;
  logic              mv;
  logic [WORD_W-1:0] md, p_word;
  logic [IDX_W-1:0]  ms, p_src;
  logic [31:0]       mts, p_ts;
  logic [NBLK-1:0]   msticky;

  logic [NBLK-1:0] last_req;
  logic            last_valid, last_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [NBLK-1:0] v);
    int r = -1;
    for (int i = 0; i < NBLK; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic cycle_body();
    logic [NBLK-1:0] exp_req;
    logic            exp_rst, idle, flush_go;
    int              g;
    empty      = drv_empty;
    oflow      = drv_oflow;
    clr        = drv_clr;
    flush      = drv_flush;
    host.ready = drv_ready;
    for (int k = 0; k < NBLK; k++) begin
      if (cyc >= blk_start[k] && cyc < blk_start[k] + WORD_W) bits[k] = blk_word[k][cyc - blk_start[k]];
      else bits[k] = 1'($urandom_range(0, 1));
    end
    #1;
    idle     = (cyc >= m_free_at);
    exp_rst  = (cyc >= m_rst_from) && (cyc < m_rst_from + RST_C);
    exp_req  = '0;
    flush_go = 1'b0;
    g        = -1;
    if (idle) begin
      if (drv_flush) flush_go = 1'b1;
      else if (drv_empty != '1 && (!mv || drv_ready)) begin
        for (int i = 0; i < NBLK; i++)
          if (g < 0 && !drv_empty[(ptr + i) % NBLK]) g = (ptr + i) % NBLK;
        exp_req = NBLK'(1) << g;
      end
    end
    chk("blk_req", req, exp_req);
    chk("blk_rst", blk_rst, exp_rst);
    chk("busy", busy, !idle);
    chk("out_valid", host.valid, mv);
    if (mv) begin
      chk("out_data", host.data, md);
      chk("out_src", host.src, ms);
`ifdef READOUT_TIMESTAMP_EN
      chk("out_ts", host.ts, mts);
`endif
    end
    chk("oflow_sticky", sticky, msticky);
    last_req   = req;
    last_valid = host.valid;
    last_rst   = blk_rst;
    for (int k = 0; k < NBLK; k++) begin
      if (req[k]) begin
        blk_word[k]  = force_en ? force_word : WORD_W'({$urandom(), $urandom()});
        force_en     = 1'b0;
        blk_start[k] = cyc + 1 + SKEW;
      end
    end
    if (g >= 0) begin
      ptr       = (g + 1) % NBLK;
      m_free_at = cyc + LAT;
      m_done    = cyc + LAT - 1;
      p_word    = blk_word[g];
      p_src     = IDX_W'(g);
      p_ts      = 32'(cyc);
    end
    if (flush_go) begin
      m_rst_from = cyc + 1;
      m_free_at  = cyc + 1 + RST_C + SET_C;
      ptr        = 0;
    end
    if (cyc == m_done) begin
      mv = 1'b1; md = p_word; ms = p_src; mts = p_ts;
    end else if (mv && drv_ready) mv = 1'b0;
    if (flush_go) mv = 1'b0;
    msticky = (msticky & ~{NBLK{drv_clr}}) | drv_oflow;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    cycle_body();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0; m_rst_from = 0; m_free_at = RST_C + SET_C; m_done = -1; ptr = 0;
    mv = 1'b0; md = '0; ms = '0; mts = '0; msticky = '0;
    for (int k = 0; k < NBLK; k++) blk_start[k] = -1000;
    cycle_body();
    chk("rst_out_data", host.data, '0);
    chk("rst_out_src", host.src, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sticky_vec_t tbl [8];
    int t, v, n, nreq, rstcnt, last_rst_cyc, delivered, r;
    int got [6];
    int tc [6];
    int exp_order [6] = '{1, 5, 6, 1, 5, 6};
    tbl[0] = '{8'h08, 1'b0, 8'h08};
    tbl[1] = '{8'h00, 1'b0, 8'h08};
    tbl[2] = '{8'h08, 1'b1, 8'h08};
    tbl[3] = '{8'h00, 1'b0, 8'h08};
    tbl[4] = '{8'h00, 1'b1, 8'h00};
    tbl[5] = '{8'h00, 1'b0, 8'h00};
    tbl[6] = '{8'h81, 1'b0, 8'h81};
    tbl[7] = '{8'h00, 1'b1, 8'h00};
    for (int k = 0; k < NBLK; k++) begin
      blk_start[k] = -1000;
      blk_word[k]  = '0;
    end

    do_reset();
    repeat (RST_C + SET_C) step();

    for (int i = 0; i < 8; i++) begin
      drv_oflow = tbl[i].oflow;
      drv_clr   = tbl[i].clr;
      step();
      drv_oflow = '0;
      drv_clr   = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("sticky_vec%0d", i), sticky, tbl[i].exp);
    end

    // Single word from block 2
    force_en = 1'b1; force_word = 36'h912345678; drv_empty = ~8'h04;
    t = -1;
    for (int s = 0; s < 20 && t < 0; s++) begin
      step();
      if (last_req != '0) t = cyc - 1;
    end
    drv_empty = '1;
    chk("single_req_seen", t >= 0, 1);
    chk("single_req_vec", last_req, 8'h04);
    v = -1;
    for (int s = 0; s < LAT + 10 && v < 0; s++) begin
      step();
      if (last_valid) v = cyc - 1;
    end
    chk("single_latency", v - t, LAT);
    chk("single_data", host.data, 36'h912345678);
    chk("single_src", host.src, 2);

    // Round-robin from a fresh pointer
    drv_empty = ~8'h62;
    do_reset();
    n = 0;
    for (int s = 0; s < 400 && n < 6; s++) begin
      step();
      if (last_req != '0) begin
        got[n] = oh2i(last_req);
        tc[n]  = cyc - 1;
        n++;
      end
    end
    chk("rr_count", n, 6);
    chk("rr_first_after_reset", tc[0], RST_C + SET_C);
    for (int i = 0; i < n; i++) chk($sformatf("rr_idx%0d", i), got[i], exp_order[i]);
    for (int i = 1; i < n; i++) chk($sformatf("rr_gap%0d", i), tc[i] - tc[i-1], LAT);

    // Backpressure
    drv_empty = '1;
    repeat (LAT + 5) step();
    drv_ready = 1'b0; drv_empty = ~8'h62;
    nreq = 0;
    for (int s = 0; s < 100; s++) begin
      step();
      if (last_req != '0) nreq++;
    end
    chk("bp_one_req", nreq, 1);
    chk("bp_valid_held", last_valid, 1);
    drv_ready = 1'b1;
    step();
    chk("bp_req_on_ready", last_req != '0, 1);

    // Flush raised at bit 10 of the word just requested
    repeat (SKEW + 10) step();
    drv_flush = 1'b1;
    rstcnt = 0; last_rst_cyc = -1; delivered = 0;
    for (int s = 0; s < 80; s++) begin
      step();
      if (last_valid && rstcnt == 0) delivered = 1;
      if (last_rst) begin
        rstcnt++;
        last_rst_cyc = cyc - 1;
        drv_flush = 1'b0;
      end else if (rstcnt > 0) break;
    end
    drv_flush = 1'b0;
    chk("flush_word_delivered", delivered, 1);
    chk("flush_rst_len", rstcnt, RST_C);
    r = -1;
    for (int s = 0; s < 40 && r < 0; s++) begin
      step();
      if (last_req != '0) r = cyc - 1;
    end
    chk("flush_settle_gap", r - last_rst_cyc, SET_C + 1);
    chk("flush_lowest_idx", oh2i(last_req), 1);

    // Reset in the middle of a capture
    repeat (20) step();
    do_reset();
    repeat (RST_C + SET_C) step();

    // Random traffic
    for (int s = 0; s < 3000; s++) begin
      if (s % 4 == 0) drv_empty = NBLK'($urandom());
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_flush = ($urandom_range(0, 199) == 0);
      drv_oflow = ($urandom_range(0, 15) == 0) ? (NBLK'(1) << $urandom_range(0, NBLK - 1)) : '0;
      drv_clr   = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
